// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: E-stage multiply/divide sequencer that owns the architectural HI/LO pair.
// Define MDU_MADD_EN to enable the op 6 accumulate family (madd/maddu/msub/msubu).
module md_unit_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        sub,
  input  logic        sgn,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        IntReq,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MACC  = 3'd6;

  logic [0:0]  state_r;
  logic [3:0]  cnt_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;

  logic        acc_s;
  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic        a_neg_s;
  logic        b_neg_s;
  logic [31:0] a_abs_s;
  logic [31:0] b_abs_s;
  logic [31:0] b_safe_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [63:0] res_s;
  logic        res_we_s;

  assign acc_s = start & ~busy & ~IntReq;
  assign busy  = (state_r == ST_RUN);
  assign stall = md_use_D & (busy | (start & ~IntReq));

  assign smul_s = $signed({{32{a_r[31]}}, a_r}) * $signed({{32{b_r[31]}}, b_r});
  assign umul_s = {32'd0, a_r} * {32'd0, b_r};

  // One unsigned divider serves both div and divu: signed division works on magnitudes.
  assign a_neg_s  = (op_r == OP_DIV) & a_r[31];
  assign b_neg_s  = (op_r == OP_DIV) & b_r[31];
  assign a_abs_s  = a_neg_s ? (32'd0 - a_r) : a_r;
  assign b_abs_s  = b_neg_s ? (32'd0 - b_r) : b_r;
  assign b_safe_s = (b_abs_s == 32'd0) ? 32'd1 : b_abs_s;
  assign uq_s     = a_abs_s / b_safe_s;
  assign ur_s     = a_abs_s % b_safe_s;
  assign q_s      = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
  assign r_s      = a_neg_s ? (32'd0 - ur_s) : ur_s;

`ifdef MDU_MADD_EN
  logic        sub_r;
  logic        sgn_r;
  logic [63:0] prod_s;
  logic [63:0] macc_s;

  // Accumulate reads HI/LO at commit time, so earlier mthi/mtlo are honoured.
  assign prod_s = sgn_r ? smul_s : umul_s;
  assign macc_s = sub_r ? ({HI, LO} - prod_s) : ({HI, LO} + prod_s);
`else
  logic unused_s;

  assign unused_s = ^{sub, sgn};
`endif

  // Select the value committed to {HI,LO} when the busy count expires.
  always_comb begin
    res_s    = {HI, LO};
    res_we_s = 1'b1;
    case (op_r)
      OP_MULT:  res_s = smul_s;
      OP_MULTU: res_s = umul_s;
      OP_DIV, OP_DIVU: begin
        if (b_r == 32'd0) begin
          res_we_s = 1'b0;
        end else begin
          res_s = {r_s, q_s};
        end
      end
`ifdef MDU_MADD_EN
      OP_MACC:  res_s = macc_s;
`endif
      default:  res_we_s = 1'b0;
    endcase
  end

  // Sequencer: accept in IDLE, count down in RUN, commit on the last busy cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      a_r     <= 32'd0;
      b_r     <= 32'd0;
      op_r    <= 3'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
`ifdef MDU_MADD_EN
      sub_r   <= 1'b0;
      sgn_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_s) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_r     <= A;
                b_r     <= B;
                op_r    <= op;
                cnt_r   <= MUL_CNT;
                state_r <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                a_r     <= A;
                b_r     <= B;
                op_r    <= op;
                cnt_r   <= DIV_CNT;
                state_r <= ST_RUN;
              end
`ifdef MDU_MADD_EN
              OP_MACC: begin
                a_r     <= A;
                b_r     <= B;
                op_r    <= op;
                sub_r   <= sub;
                sgn_r   <= sgn;
                cnt_r   <= MUL_CNT;
                state_r <= ST_RUN;
              end
`endif
              OP_MTHI: HI <= A;
              OP_MTLO: LO <= A;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (cnt_r > 4'd1) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (res_we_s) begin
              HI <= res_s[63:32];
              LO <= res_s[31:0];
            end
            cnt_r   <= 4'd0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed literal cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_md_unit_ctrl;

  localparam int MUL_CYCLES = 5;
  localparam int DIV_CYCLES = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        sub;
  logic        sgn;
  logic [31:0] A;
  logic [31:0] B;
  logic        IntReq;
  logic        md_use_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  int          m_rem;
  logic [2:0]  m_op;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sub;
  logic        m_sgn;
  logic [63:0] m_hilo;

  md_unit_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sub(sub), .sgn(sgn),
    .A(A), .B(B), .IntReq(IntReq), .md_use_D(md_use_D),
    .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a finished operation, from plain 64-bit arithmetic.
  function automatic logic [63:0] md_model(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic s_sub,
                                           input logic s_sgn, input logic [63:0] hilo);
    longint      sa;
    longint      sb;
    logic [63:0] p;
    logic [63:0] q;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return hilo;
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return hilo;
        return {a % b, a / b};
      end
      3'd6: begin
        p = s_sgn ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
        return s_sub ? (hilo - p) : (hilo + p);
      end
      default: return hilo;
    endcase
  endfunction

  // Reference model: remaining busy cycles plus architectural {HI,LO}.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem  <= 0;
      m_hilo <= 64'd0;
      m_op   <= 3'd0;
      m_a    <= 32'd0;
      m_b    <= 32'd0;
      m_sub  <= 1'b0;
      m_sgn  <= 1'b0;
    end else if (m_rem > 0) begin
      if (m_rem == 1) m_hilo <= md_model(m_op, m_a, m_b, m_sub, m_sgn, m_hilo);
      m_rem <= m_rem - 1;
    end else if (start && !IntReq) begin
      if (op <= 3'd3 || (op == 3'd6 && MADD_ON)) begin
        m_rem <= (op == 3'd2 || op == 3'd3) ? DIV_CYCLES : MUL_CYCLES;
        m_op  <= op;
        m_a   <= A;
        m_b   <= B;
        m_sub <= sub;
        m_sgn <= sgn;
      end else if (op == 3'd4) begin
        m_hilo[63:32] <= A;
      end else if (op == 3'd5) begin
        m_hilo[31:0] <= A;
      end
    end
  end

  // Per-cycle comparison just before the rising edge, when inputs and state are settled.
  always @(negedge clk) begin
    #4;
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_rem > 0));
      check("stall", 64'(stall), 64'(md_use_D & ((m_rem > 0) | (start & ~IntReq))));
      check("HI", 64'(HI), 64'(m_hilo[63:32]));
      check("LO", 64'(LO), 64'(m_hilo[31:0]));
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic s_sub, input logic s_sgn, output int n);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b; sub = s_sub; sgn = s_sgn;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = 3'd0; sub = 1'b0; sgn = 1'b0;
    A = 32'd0; B = 32'd0; IntReq = 1'b0; md_use_D = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, n);
    check("mult_lat", 64'(n), 64'd5);
    check("mult_hi", 64'(HI), 64'hFFFF_FFFF);
    check("mult_lo", 64'(LO), 64'hFFFF_FFFA);

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, n);
    check("multu_hi", 64'(HI), 64'h0000_0002);
    check("multu_lo", 64'(LO), 64'hFFFF_FFFA);

    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, n);
    check("div_lat", 64'(n), 64'd10);
    check("div_lo", 64'(LO), 64'hFFFF_FFFD);
    check("div_hi", 64'(HI), 64'hFFFF_FFFF);

    run_op(3'd3, 32'd7, 32'd0, 1'b0, 1'b0, n);
    check("div0_lat", 64'(n), 64'd10);
    check("div0_hi", 64'(HI), 64'hFFFF_FFFF);
    check("div0_lo", 64'(LO), 64'hFFFF_FFFD);

    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, n);
    check("divovf_lo", 64'(LO), 64'h8000_0000);
    check("divovf_hi", 64'(HI), 64'h0000_0000);

    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4; md_use_D = 1'b1;
    #1 check("stall_start", 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      #1 check("stall_busy", 64'(stall), 64'd1);
      n++;
      @(negedge clk);
    end
    #1 check("stall_after", 64'(stall), 64'd0);
    check("stall_lat", 64'(n), 64'd5);
    check("stall_lo", 64'(LO), 64'd12);
    md_use_D = 1'b0;

    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd7; B = 32'd9; IntReq = 1'b1; md_use_D = 1'b1;
    #1 check("int_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; IntReq = 1'b0; md_use_D = 1'b0;
    check("int_busy", 64'(busy), 64'd0);
    check("int_hi", 64'(HI), 64'd0);
    check("int_lo", 64'(LO), 64'd12);

    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 3'd0; A = 32'd5; B = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("midrun_lat", 64'(n), 64'd3);
    check("midrun_hi", 64'(HI), 64'd0);
    check("midrun_lo", 64'(LO), 64'd6);

    @(negedge clk);
    start = 1'b1; op = 3'd4; A = 32'h1234_5678;
    @(negedge clk);
    op = 3'd5; A = 32'h9ABC_DEF0;
    check("mthi_hi", 64'(HI), 64'h1234_5678);
    @(negedge clk);
    start = 1'b0;
    check("mtlo_hi", 64'(HI), 64'h1234_5678);
    check("mtlo_lo", 64'(LO), 64'h9ABC_DEF0);

    @(negedge clk);
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check("rstrun_busy", 64'(busy), 64'd0);
    check("rstrun_hi", 64'(HI), 64'd0);
    check("rstrun_lo", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'd4, 32'd5, 1'b0, 1'b0, n);
    check("after_rst_lat", 64'(n), 64'd5);
    check("after_rst_lo", 64'(LO), 64'd20);

    run_op(3'd4, 32'd0, 32'd0, 1'b0, 1'b0, n);
    run_op(3'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, n);
    run_op(3'd6, 32'd1, 32'd1, 1'b0, 1'b0, n);
`ifdef MDU_MADD_EN
    check("madd_lat", 64'(n), 64'd5);
    check("madd_hi", 64'(HI), 64'd1);
    check("madd_lo", 64'(LO), 64'd0);
    run_op(3'd6, 32'd1, 32'd1, 1'b1, 1'b1, n);
    check("msub_hi", 64'(HI), 64'd0);
    check("msub_lo", 64'(LO), 64'hFFFF_FFFF);
`else
    check("op6_lat", 64'(n), 64'd0);
    check("op6_hi", 64'(HI), 64'd0);
    check("op6_lo", 64'(LO), 64'hFFFF_FFFF);
`endif

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 199) == 0);
      start    = ($urandom_range(0, 9) < 4);
      op       = 3'($urandom_range(0, 7));
      sub      = 1'($urandom_range(0, 1));
      sgn      = 1'($urandom_range(0, 1));
      A        = pick();
      B        = pick();
      IntReq   = ($urandom_range(0, 7) == 0);
      md_use_D = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; IntReq = 1'b0; md_use_D = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
# md_unit_ctrl

Multiply/divide sequencer that owns the HI/LO register pair feeding the write-back select. Sits in E stage: accepts an operation and operands from the E-stage instruction, models fixed multi-cycle latency with a busy counter, and raises a stall toward the hazard unit while a D-stage instruction needs the unit. It suppresses the start of an operation when an interrupt or exception is taken in the same cycle.

## Interface
- MUL_CYCLES, 5, busy cycles for mult/multu (1–15)
- DIV_CYCLES, 10, busy cycles for div/divu (1–15)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  E-stage instruction is an MDU operation, valid this cycle
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd/maddu/msub select space (see Configuration), 7 reserved
- sub  input  1  with op=6: 0 add, 1 subtract
- sgn  input  1  with op=6: 1 signed, 0 unsigned
- A  input  32  rs operand (V1_E after forwarding)
- B  input  32  rt operand (V2_E after forwarding)
- IntReq  input  1  exception/interrupt taken this cycle; kills E-stage start
- md_use_D  input  1  D-stage instruction is mult/div/mthi/mtlo/mfhi/mflo
- busy  output  1  operation in flight
- stall  output  1  freeze PC/F/D, bubble into E
- HI  output  32  architectural HI
- LO  output  32  architectural LO

## Operation
- Accept condition: acc = start & ~busy & ~IntReq. start while busy or with IntReq is ignored (no state change).
- States: IDLE (busy=0, cnt=0), RUN (busy=1, cnt≥1).
- IDLE + acc, op 0–3 or 6: latch A, B, op, sub, sgn; cnt←MUL_CYCLES (ops 0,1,6) or DIV_CYCLES (ops 2,3); busy←1 → RUN.
- IDLE + acc, op 4: HI←A at that edge; op 5: LO←A. No busy. op 7: no effect.
- RUN: each edge with cnt>1 → cnt−1. Edge with cnt==1 → commit result to HI/LO, cnt←0, busy←0 → IDLE.
- Results, computed from latched operands only:
  - mult/multu: {HI,LO} ← 64-bit signed/unsigned product.
  - div/divu: LO ← quotient, HI ← remainder; signed truncates toward zero, remainder takes dividend's sign. 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Divisor 0: HI, LO unchanged at commit; busy timing identical.
  - op 6: {HI,LO} ← {HI,LO} ± product, mod 2^64, HI/LO sampled at commit.
- IntReq during RUN does not abort; the operation completes (its instruction has passed E).
- stall = md_use_D & (busy | (start & ~IntReq)).
- HI/LO are the values read by mfhi/mflo in W via the write-back select; no internal forwarding of in-flight results.

## Timing
- Reset: busy=0, stall=0, cnt=0, HI=0, LO=0, latched operands 0; effective immediately (async), including mid-RUN — in-flight result discarded.
- mult with MUL_CYCLES=5: start at edge t → busy high for cycles t+1…t+5; HI/LO valid after edge t+5; busy=0 in cycle t+6.
- Back-to-back: a new start is accepted in the first cycle busy=0; no dead cycle.
- mthi/mtlo: HI/LO updated at the accepting edge; visible next cycle.
- stall is combinational from inputs and busy; busy and HI/LO are registered.

## Configuration
- MDU_MADD_EN defined: op 6 performs madd/maddu/msub/msubu per sub/sgn with MUL_CYCLES latency.
- MDU_MADD_EN undefined: op 6 treated as op 7 (accepted, no state change, no busy); accumulate datapath not instantiated.

## Test plan
- Reset then mult A=0xFFFFFFFE, B=3 signed → busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 → HI/LO unchanged.
- start with md_use_D=1 → stall=1 in start cycle and every busy cycle, 0 the cycle busy falls; start+IntReq same cycle → busy stays 0, stall=0, HI/LO unchanged.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0 on consecutive edges → HI/LO hold those values; mult start issued mid-RUN is ignored and HI/LO reflect only the first op.
- Assert reset at cycle 3 of a div → busy=0, HI=LO=0 immediately; next start accepted normally.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd unsigned A=1, B=1 → HI=1, LO=0; msub signed A=1, B=1 → HI=0, LO=0xFFFFFFFF. Without macro: op 6 leaves HI/LO unchanged, busy stays 0.
